ram_sync_arbiter: RTL
=====================

Name: ram_sync_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared single-port synchronous RAM: 8-bit address, 8-bit data, write-enable high = write, registered read.
- Accepts read/write commands from requesters A and B with a req/gnt handshake.
- Drives the RAM command inputs from registers and returns read data to the owning requester with a fixed latency.
- Sits between the RAM and its users (CPU datapath, debug loader).

Parameters:
AW, 8, address width
DW, 8, data width
DEPTH, 11, number of implemented RAM words (valid addresses 0..DEPTH-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_a  in  1  requester A command valid; held until gnt_a
we_a  in  1  A: 1=write, 0=read
addr_a  in  AW  A address
wdata_a  in  DW  A write data
gnt_a  out  1  A command accepted (1-cycle pulse)
rvalid_a  out  1  A read data valid (1-cycle pulse)
rdata_a  out  DW  A read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  as for A
ram_addr  out  AW  to RAM address
ram_din  out  DW  to RAM write data
ram_en  out  1  to RAM write enable (1=write)
ram_dout  in  DW  from RAM registered read data

Behaviour:
- Reset (async, immediate): FSM=IDLE, all gnt/rvalid=0, rdata_a/b=0, ram_addr=0, ram_din=0, ram_en=0, last-served pointer=B (so A wins first tie).
- FSM IDLE: at a rising edge with any req high, select winner, assert its gnt for the next cycle, register ram_addr/ram_din from the winner, set ram_en=we of winner, go to HOLD. With no req, stay in IDLE; ram_en stays 0.
- FSM HOLD: exactly one cycle. The RAM executes the command at the edge leaving HOLD. At that edge: ram_en<=0, gnt<=0, return to IDLE. No grant is issued in HOLD; this absorbs the requester dropping req after gnt. Peak throughput: one command per 2 cycles.
- Arbitration: only one req high wins. Both high: the requester not equal to last-served wins. The pointer updates on every grant.
- Read return: a read granted at edge k is executed by the RAM at k+1. rdata_x<=ram_dout and rvalid_x<=1 at k+2; rvalid_x is a 1-cycle pulse. rdata_x holds its value until the next read for that requester.
- A new grant at k+2 may overlap the rvalid of the previous read; the tag pipeline (owner + is_read, 2 stages) must keep them independent.
- Writes produce no rvalid.
- ram_addr/ram_din hold their last values in IDLE. Reads issued by the RAM while ram_en=0 are ignored.
- Commands issued to requesters are never dropped: a losing req stays pending and is granted next IDLE.
- Reset mid-operation: in-flight tags are cleared, no rvalid is emitted, and a pending write in HOLD is aborted because ram_en is cleared asynchronously.

Optional Feature:
- Macro RAM_ARB_RANGE_CHK_EN.
- Defined: a command with addr >= DEPTH is granted normally, but ram_en is forced to 0 (write suppressed). A read returns rdata=0 with rvalid at the normal latency. Output err_x (1-bit per requester, reset 0) pulses 1 cycle together with gnt_x.
- Undefined: no err ports; addresses pass unchecked.

Decomposition:
- Package ram_arb_pkg: FSM state enum {IDLE, HOLD}, requester ID constants REQ_A=0/REQ_B=1, default AW/DW/DEPTH constants.
- One natural sub-module: rr_arb2, a 2-way round-robin pick with pointer register, used by the top FSM in IDLE.

Test Plan:
- RAM preloaded 0:90 … 10:101. A reads addr 3 → gnt_a 1 cycle after req, rvalid_a 2 cycles after gnt, rdata_a=60.
- B writes addr 5 = 0xAA, then B reads addr 5 → ram_en=1 for exactly one cycle; rdata_b=0xAA.
- req_a and req_b high together and held: A reads addr 0, B reads addr 1, repeated → grants alternate A,B,A,B. rdata_a=90, rdata_b=80, never cross-routed.
- Back-to-back reads: A addr 9 and B addr 10 granted 2 cycles apart → rvalid_a/rdata_a=100 and rvalid_b/rdata_b=101 in consecutive grant windows, no overlap corruption.
- Assert rst in HOLD of a B write to addr 2 = 0x11 → outputs zero immediately. A later read of addr 2 returns 70.
- With RAM_ARB_RANGE_CHK_EN: A writes addr 11 = 0x55 → err_a pulse, ram_en stays 0. A reads addr 11 → rdata_a=0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter:
// FSM states, requester IDs and the read-return tag.
package ram_arb_pkg;

    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 11;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One stage of the read-return pipeline: who owns the read, and whether
    // it targeted an unimplemented word (only ever set with range checking).
    typedef struct packed {
        logic vld;
        logic owner;
        logic oor;
    } tag_t;

endpackage

// File: rtl/ram_sync_arbiter_rr_arb2.sv
// Two-way round-robin pick. The last-served pointer resets to B so that
// A wins the first tie; it advances only when a grant is actually issued.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       any,
    output logic       pick
);

    logic last;

    always_comb begin
        any  = |req;
        pick = REQ_A;
        if (req[0] && req[1]) begin
            pick = (last == REQ_B) ? REQ_A : REQ_B;
        end else if (req[1]) begin
            pick = REQ_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= REQ_B;
        end else if (advance && any) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/ram_sync_arbiter.sv
// Round-robin arbiter/sequencer for a single-port synchronous RAM with
// registered read. Optional address range check: RAM_ARB_RANGE_CHK_EN.
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x stable and
// holds them until it sees gnt_x; the command is accepted on the clock edge
// that raises the one-cycle gnt_x pulse. Reads return on rvalid_x two edges
// after that grant edge; writes return nothing.
module ram_sync_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
`ifdef RAM_ARB_RANGE_CHK_EN
    output logic          err_a,
    output logic          err_b,
`endif
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_en,
    input  logic [DW-1:0] ram_dout,
    output state_t        state
);

    state_t        state_n;
    logic          any;
    logic          pick;
    logic          grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;
    tag_t          tag0;
    tag_t          tag1;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req_b, req_a}),
        .advance (grant),
        .any     (any),
        .pick    (pick)
    );

    always_comb begin
        sel_we    = (pick == REQ_B) ? we_b    : we_a;
        sel_addr  = (pick == REQ_B) ? addr_b  : addr_a;
        sel_wdata = (pick == REQ_B) ? wdata_b : wdata_a;
`ifdef RAM_ARB_RANGE_CHK_EN
        sel_oor   = ({1'b0, sel_addr} >= (AW + 1)'(DEPTH));
`else
        sel_oor   = 1'b0;
`endif
    end

    // HOLD lasts one cycle so a requester has time to drop req after gnt.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    grant   = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_en   <= 1'b0;
            tag0     <= '0;
            tag1     <= '0;
        end else begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            ram_en   <= 1'b0;
            tag0     <= '0;
            tag1     <= tag0;
            // tag1 describes the read the RAM executed on the previous edge.
            rvalid_a <= tag1.vld && (tag1.owner == REQ_A);
            rvalid_b <= tag1.vld && (tag1.owner == REQ_B);
            if (tag1.vld && (tag1.owner == REQ_A)) begin
                rdata_a <= tag1.oor ? '0 : ram_dout;
            end
            if (tag1.vld && (tag1.owner == REQ_B)) begin
                rdata_b <= tag1.oor ? '0 : ram_dout;
            end
            if (grant) begin
                gnt_a     <= (pick == REQ_A);
                gnt_b     <= (pick == REQ_B);
                ram_addr  <= sel_addr;
                ram_din   <= sel_wdata;
                ram_en    <= sel_we && !sel_oor;
                tag0.vld   <= !sel_we;
                tag0.owner <= pick;
                tag0.oor   <= sel_oor;
            end
        end
    end

`ifdef RAM_ARB_RANGE_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_a <= 1'b0;
            err_b <= 1'b0;
        end else begin
            err_a <= grant && sel_oor && (pick == REQ_A);
            err_b <= grant && sel_oor && (pick == REQ_B);
        end
    end
`endif

endmodule
